// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction memory request/ack and the valid/ready
// handoff of fetched words to decode.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output ir_out,
        output ir_pc,
        output ir_valid,
        input  ir_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  ir_out,
        input  ir_pc,
        input  ir_valid,
        output ir_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: steers the PC register, runs the imem
// handshake, hands words to decode and arbitrates PC redirects.
//
// state   | meaning
// FETCH   | request outstanding at pc_cur, waiting for imem_ack
// HOLD    | fetched word presented to decode, waiting for ir_ready
// HALTED  | no fetching until halt drops or an interrupt is accepted
module fetch_sequencer (
    input  logic                     clk,
    input  logic                     rst,
    fetch_sequencer_if.master        bus,
    input  logic [31:0]              pc_cur,
    output logic                     pc_ld,
    output logic                     pc_inc,
    output logic [31:0]              pc_in,
    input  logic                     br_take,
    input  logic [31:0]              br_target,
    input  logic                     jmp_take,
    input  logic [31:0]              jmp_target,
    input  logic                     int_req,
    input  logic                     eret,
    input  logic                     halt,
    output logic                     int_ack,
    output logic [31:0]              epc,
    output logic                     int_en
);
    localparam logic [31:0] INT_VEC   = 32'h0000_0200;

    localparam logic [1:0]  ST_FETCH  = 2'd0;
    localparam logic [1:0]  ST_HOLD   = 2'd1;
    localparam logic [1:0]  ST_HALTED = 2'd2;

    logic [1:0] state;
    logic       active;
    logic       int_take;
    logic       eret_take;
    logic       jmp_sel;
    logic       br_sel;
    logic       redirect;
    logic       ack_seen;
    logic       xfer;

    // Only the interrupt may redirect out of HALTED; reset masks everything.
    always_comb begin
        active    = !rst && (state != ST_HALTED);
        int_take  = !rst && int_req && int_en;
        eret_take = active && eret && !int_take;
        jmp_sel   = active && jmp_take && !int_take && !eret;
        br_sel    = active && br_take && !int_take && !eret && !jmp_take;
        redirect  = int_take || eret_take || jmp_sel || br_sel;
        ack_seen  = bus.imem_req && bus.imem_ack;
        xfer      = (state == ST_HOLD) && bus.ir_valid && bus.ir_ready && !redirect;
    end

    always_comb begin
        pc_ld  = redirect;
        pc_inc = ack_seen && !redirect;
        pc_in  = 32'h0;
        if (int_take)       pc_in = INT_VEC;
        else if (eret_take) pc_in = epc;
        else if (jmp_sel)   pc_in = jmp_target;
        else if (br_sel)    pc_in = br_target;
    end

    assign bus.imem_req  = !rst && (state == ST_FETCH);
    assign bus.imem_addr = pc_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_FETCH;
            bus.ir_out   <= 32'h0;
            bus.ir_pc    <= 32'h0;
            bus.ir_valid <= 1'b0;
            epc          <= 32'h0;
            int_ack      <= 1'b0;
            int_en       <= 1'b1;
        end else begin
            int_ack <= int_take;
            if (int_take) begin
                epc    <= (state == ST_HOLD) ? bus.ir_pc : pc_cur;
                int_en <= 1'b0;
            end else if (eret_take) begin
                int_en <= 1'b1;
            end

            // A redirect squashes whatever word is in flight or held.
            if (redirect) begin
                state        <= ST_FETCH;
                bus.ir_valid <= 1'b0;
            end else begin
                case (state)
                    ST_FETCH: begin
                        if (ack_seen) begin
                            bus.ir_out   <= bus.imem_rdata;
                            bus.ir_pc    <= pc_cur;
                            bus.ir_valid <= 1'b1;
                            state        <= ST_HOLD;
                        end else if (halt) begin
                            state <= ST_HALTED;
                        end
                    end
                    ST_HOLD: begin
                        if (xfer) begin
                            bus.ir_valid <= 1'b0;
                            state        <= ST_FETCH;
                        end
                    end
                    ST_HALTED: begin
                        if (!halt) state <= ST_FETCH;
                    end
                    default: state <= ST_FETCH;
                endcase
            end
        end
    end
endmodule
